pp_fifo_mc: RTL
===============

// Module: pp_fifo_mc
// PURPOSE
//  Multi-channel, parametrised successor to the single-lane pp FIFO.
//  CHANNELS independent first-word-fall-through (FWFT) FIFOs; any DEPTH >= 2, power of 2 not required.
//  Adds: correctly sized occupancy counts; almost-full and almost-empty flags;
//  sticky overflow and underflow error flags; per-channel clear.
//  Sits between packet producers and the per-lane consumers in the pp datapath.
// PARAMETERS
//  CHANNELS    2   number of independent FIFO lanes (>=1)
//  DEPTH       6   entries per lane (>=2)
//  DATA_WIDTH  32  bits per entry
//  AF_THRESH   4   almost_full asserts when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH   1   almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
// PORTS  (C=CHANNELS, W=DATA_WIDTH, CW=$clog2(DEPTH+1); lane n occupies slice [n*X +: X])
//  clk           in   1     clock; all state updates on rising edge
//  reset_n       in   1     asynchronous active-low reset
//  clear         in   C     per-lane synchronous flush of pointers/count
//  err_clr       in   C     per-lane clear of sticky overflow/underflow
//  push          in   C     per-lane write request
//  pop           in   C     per-lane read request (acknowledges data_out)
//  data_in       in   C*W   per-lane write data
//  data_out      out  C*W   per-lane head entry (FWFT); 0 when lane empty
//  count         out  C*CW  per-lane occupancy 0..DEPTH
//  empty         out  C     count==0
//  full          out  C     count==DEPTH
//  almost_full   out  C     count>=AF_THRESH
//  almost_empty  out  C     count<=AE_THRESH
//  overflow      out  C     sticky: push rejected
//  underflow     out  C     sticky: pop rejected
// BEHAVIOUR  (per lane, lanes fully independent)
//  Reset: wr_ptr=rd_ptr=0, count=0, empty=1, full=0, overflow=underflow=0, data_out=0.
//   almost_* reflect count=0 immediately. Storage contents are not reset.
//  Acceptance: pop_ok = pop & ~empty.
//   push_ok = push & (~full | pop_ok); a push to a full lane with a same-cycle pop is accepted.
//  push_ok: mem[wr_ptr]<=data_in; wr_ptr advances, wrapping DEPTH-1 -> 0.
//  pop_ok: rd_ptr advances with the same wrap rule.
//  count: +1 on push_ok&~pop_ok; -1 on ~push_ok&pop_ok; unchanged otherwise.
//   count never leaves 0..DEPTH.
//  FWFT latency: a word pushed into an empty lane appears on data_out the next cycle.
//   data_out = mem[rd_ptr] when ~empty, else all-zero.
//  Push and pop on an empty lane: the push is accepted and the pop is rejected.
//   Next cycle count=1, data_out=data_in.
//  overflow sets on push & ~push_ok. underflow sets on pop & ~pop_ok.
//   Both hold until err_clr or reset. If set and err_clr occur together, set wins.
//  clear: next cycle pointers=0 and count=0. Overrides same-cycle push/pop: no write, no error flag update.
//   Error flags are not affected by clear.
//  Flags are combinational decodes of registered count; no extra latency.
// STRUCTURE
//  Package pp_fifo_pkg: function cnt_w(depth)=$clog2(depth+1); ptr width helper; lane-slice macros are not used.
//  Sub-module pp_fifo_lane: one circular-buffer FWFT lane with all per-lane logic.
//   pp_fifo_mc is a generate loop over CHANNELS plus port slicing only.
//  Elaboration-time checks: DEPTH>=2; AF_THRESH in 1..DEPTH; AE_THRESH<DEPTH.
// TESTING  (CHANNELS=2, DEPTH=6, W=32, AF=4, AE=1 unless stated)
//  1 Reset mid-traffic: lane0 has 3 words. reset_n=0 async ->
//    count=0, empty=1, data_out=0 without waiting for a clk edge.
//  2 Fill/drain lane0: push 1..6 -> full=1 and count=6; almost_full from count=4; push 7 -> overflow=1, count stays 6.
//    Then pop x6 -> data 1..6 in order, empty=1. Pop again -> underflow=1.
//  3 Wrap: 200 random push/pop cycles with DEPTH=5 -> order matches scoreboard, pointers wrap, count exact.
//  4 Full + simultaneous push/pop -> count stays 6, head advances, new word at tail, no overflow.
//    Empty + push/pop -> count=1, underflow=1.
//  5 clear on lane1 with push asserted, lane1 count=3 -> lane1 count=0 and no write.
//    Lane0 traffic is unaffected, overflow on lane1 is retained; err_clr then drops it.
//  6 Lane independence: lane0 full while lane1 empty, both pushing -> only lane0 overflow sets.

Source files
------------

// File: rtl/pp_fifo_pkg.sv
// Shared sizing helpers for the multi-channel pp FIFO.
// Lane logic and the top-level port slicing both derive their widths from these functions.
package pp_fifo_pkg;

    // Width of an occupancy count that must represent 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width; kept at least 1 bit so a degenerate depth still elaborates.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pp_fifo_mc_if.sv
// Bundle of per-lane control, data and status vectors for pp_fifo_mc.
// Lane n occupies slice [n*X +: X] of every vector.
interface pp_fifo_mc_if import pp_fifo_pkg::*; #(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned DEPTH      = 6,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic [CHANNELS-1:0]            clear;
    logic [CHANNELS-1:0]            err_clr;
    logic [CHANNELS-1:0]            push;
    logic [CHANNELS-1:0]            pop;
    logic [CHANNELS*DATA_WIDTH-1:0] data_in;
    logic [CHANNELS*DATA_WIDTH-1:0] data_out;
    logic [CHANNELS*CW-1:0]         count;
    logic [CHANNELS-1:0]            empty;
    logic [CHANNELS-1:0]            full;
    logic [CHANNELS-1:0]            almost_full;
    logic [CHANNELS-1:0]            almost_empty;
    logic [CHANNELS-1:0]            overflow;
    logic [CHANNELS-1:0]            underflow;

    modport master (
        output clear, err_clr, push, pop, data_in,
        input  data_out, count, empty, full, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  clear, err_clr, push, pop, data_in,
        output data_out, count, empty, full, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/pp_fifo_lane.sv
// One first-word-fall-through circular-buffer lane with occupancy count,
// threshold flags, sticky overflow/underflow and a synchronous flush.
module pp_fifo_lane import pp_fifo_pkg::*; #(
    parameter int unsigned DEPTH      = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned AF_THRESH  = 4,
    parameter int unsigned AE_THRESH  = 1,
    localparam int unsigned CW = cnt_w(DEPTH),
    localparam int unsigned PW = ptr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  err_clr,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [CW-1:0]         count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);
    if (DEPTH < 2) begin : g_bad_depth
        $error("pp_fifo_lane: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("pp_fifo_lane: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH >= DEPTH) begin : g_bad_ae
        $error("pp_fifo_lane: AE_THRESH must be below DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  ovf_q, unf_q;
    logic                  pop_ok, push_ok;

    // Non-power-of-two depths need an explicit wrap rather than natural rollover.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign data_out     = empty ? '0 : mem_q[rd_ptr_q];

    // A full lane still takes a push when the head leaves in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
                if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
                else if (!push_ok && pop_ok) count_q <= count_q - CW'(1);
            end
            // A new error in the same cycle as err_clr stays visible.
            ovf_q <= (~clear & push & ~push_ok) | (ovf_q & ~err_clr);
            unf_q <= (~clear & pop & ~pop_ok) | (unf_q & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem_q[wr_ptr_q] <= data_in;
    end
endmodule

// File: rtl/pp_fifo_mc.sv
// Multi-channel FWFT FIFO: CHANNELS independent pp_fifo_lane instances
// wired to per-lane slices of the bus interface.
module pp_fifo_mc import pp_fifo_pkg::*; #(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned DEPTH      = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned AF_THRESH  = 4,
    parameter int unsigned AE_THRESH  = 1
) (
    input logic        clk,
    input logic        reset_n,
    pp_fifo_mc_if.slave bus
);
    localparam int unsigned CW = cnt_w(DEPTH);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("pp_fifo_mc: CHANNELS must be >= 1");
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
        pp_fifo_lane #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH),
            .AF_THRESH  (AF_THRESH),
            .AE_THRESH  (AE_THRESH)
        ) u_lane (
            .clk          (clk),
            .reset_n      (reset_n),
            .clear        (bus.clear[n]),
            .err_clr      (bus.err_clr[n]),
            .push         (bus.push[n]),
            .pop          (bus.pop[n]),
            .data_in      (bus.data_in[n*DATA_WIDTH +: DATA_WIDTH]),
            .data_out     (bus.data_out[n*DATA_WIDTH +: DATA_WIDTH]),
            .count        (bus.count[n*CW +: CW]),
            .empty        (bus.empty[n]),
            .full         (bus.full[n]),
            .almost_full  (bus.almost_full[n]),
            .almost_empty (bus.almost_empty[n]),
            .overflow     (bus.overflow[n]),
            .underflow    (bus.underflow[n])
        );
    end
endmodule
